// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide responder.
// Signed multiply uses radix-2 Booth; unsigned divide uses restoring division.
// Both take exactly WIDTH iteration cycles. The result is returned on hi/lo
// together with a one-cycle done pulse.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi,
   output logic             div_by_zero
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_DONE
   } state_t;

   state_t                  state_q;
   logic [CNT_W-1:0]        cnt_q;
   logic signed [WIDTH-1:0] a_q;
   logic [WIDTH-1:0]        b_q;
   // Upper accumulator: Booth partial product (one guard bit so that
   // subtracting the most negative multiplicand cannot overflow) or
   // restoring-division remainder.
   logic signed [WIDTH:0]   acc_hi_q;
   // Lower accumulator: Booth multiplier bits or division quotient bits.
   logic [WIDTH-1:0]        acc_lo_q;
   logic                    qm1_q;
   logic                    busy_q;
   logic                    done_q;
   logic [WIDTH-1:0]        hi_q;
   logic [WIDTH-1:0]        lo_q;
   logic                    dbz_q;

   logic signed [WIDTH:0]   a_ext;
   logic signed [WIDTH:0]   booth_sum;
   logic signed [WIDTH:0]   mul_hi_d;
   logic [WIDTH-1:0]        mul_lo_d;
   logic                    mul_qm1_d;

   logic [WIDTH:0]          rem_sh;
   logic [WIDTH+1:0]        trial;
   logic signed [WIDTH:0]   div_hi_d;
   logic [WIDTH-1:0]        div_lo_d;
   logic                    quo_bit;

   // One Booth step: conditional add/subtract of the multiplicand, then an
   // arithmetic shift of the whole {P_hi, P_lo, q_-1} accumulator.
   always_comb begin
      a_ext     = {a_q[WIDTH-1], a_q};
      booth_sum = acc_hi_q;
      case ({acc_lo_q[0], qm1_q})
         2'b10:   booth_sum = acc_hi_q - a_ext;
         2'b01:   booth_sum = acc_hi_q + a_ext;
         default: booth_sum = acc_hi_q;
      endcase
      mul_hi_d  = booth_sum >>> 1;
      mul_lo_d  = {booth_sum[0], acc_lo_q[WIDTH-1:1]};
      mul_qm1_d = acc_lo_q[0];
   end

   // One restoring-division step: shift {R,Q} left, trial-subtract the
   // divisor, keep the difference only when it is non-negative.
   always_comb begin
      rem_sh = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
      trial  = {1'b0, rem_sh} - {2'b00, b_q};
      if (!trial[WIDTH+1]) begin
         div_hi_d = trial[WIDTH:0];
         quo_bit  = 1'b1;
      end else begin
         div_hi_d = rem_sh;
         quo_bit  = 1'b0;
      end
      div_lo_d = {acc_lo_q[WIDTH-2:0], quo_bit};
   end

   // Control FSM with registered outputs; also advances the shared datapath.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         qm1_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         dbz_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_q      <= a;
                  b_q      <= b;
                  cnt_q    <= '0;
                  acc_hi_q <= '0;
                  // Booth starts from the multiplier, division from the dividend.
                  acc_lo_q <= op ? a : b;
                  qm1_q    <= 1'b0;
                  busy_q   <= 1'b1;
                  state_q  <= op ? S_DIV : S_MUL;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_MUL: begin
               acc_hi_q <= mul_hi_d;
               acc_lo_q <= mul_lo_d;
               qm1_q    <= mul_qm1_d;
               cnt_q    <= cnt_q + 1'b1;
               if (cnt_q == LAST_ITER) begin
                  hi_q    <= mul_hi_d[WIDTH-1:0];
                  lo_q    <= mul_lo_d;
                  dbz_q   <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_DIV: begin
               acc_hi_q <= div_hi_d;
               acc_lo_q <= div_lo_d;
               cnt_q    <= cnt_q + 1'b1;
               if (cnt_q == LAST_ITER) begin
                  // A zero divisor falls out naturally as Q=all ones, R=a.
                  hi_q    <= div_hi_d[WIDTH-1:0];
                  lo_q    <= div_lo_d;
                  dbz_q   <= (b_q == '0);
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign hi          = hi_q;
   assign lo          = lo_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit (WIDTH=32).
// Expected results come from plain integer arithmetic and are queued when a
// request is driven; a monitor pops and compares on every done pulse.
module tb_muldiv_unit;

   localparam int W = 32;
   localparam int BUDGET = 200;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         start;
   logic         op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] lo;
   logic [W-1:0] hi;
   logic         div_by_zero;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
   } exp_t;

   exp_t sb_q[$];
   exp_t last_exp;
   int   vecs = 0;
   int   errs = 0;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .op          (op),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .lo          (lo),
      .hi          (hi),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   // Reference arithmetic
   function automatic exp_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t   m;
      longint p;
      if (!o) begin
         p     = longint'($signed(x)) * longint'($signed(y));
         m.hi  = p[63:32];
         m.lo  = p[31:0];
         m.dbz = 1'b0;
      end else if (y == '0) begin
         m.hi  = x;
         m.lo  = '1;
         m.dbz = 1'b1;
      end else begin
         m.hi  = x % y;
         m.lo  = x / y;
         m.dbz = 1'b0;
      end
      return m;
   endfunction

   // Monitor: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (reset_n === 1'b1 && done === 1'b1) begin
         vecs++;
         if (sb_q.size() == 0) begin
            errs++;
            $display("FAIL unexpected_done: got hi=%h lo=%h dbz=%b, expected no result", hi, lo, div_by_zero);
         end else begin
            last_exp = sb_q.pop_front();
            if ({hi, lo, div_by_zero} !== {last_exp.hi, last_exp.lo, last_exp.dbz}) begin
               errs++;
               $display("FAIL result: got hi=%h lo=%h dbz=%b, expected hi=%h lo=%h dbz=%b",
                        hi, lo, div_by_zero, last_exp.hi, last_exp.lo, last_exp.dbz);
            end
         end
      end
   end

   // Drive one request; returns at the negedge just after the accepting edge.
   task automatic start_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
      @(negedge clk);
      op    = o;
      a     = x;
      b     = y;
      start = 1'b1;
      sb_q.push_back(model(o, x, y));
      @(negedge clk);
      start = 1'b0;
   endtask

   // Bounded wait for done; n is the number of negedges waited.
   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      if (done !== 1'b1) begin
         vecs++;
         errs++;
         $display("FAIL done_timeout: no done within %0d cycles", BUDGET);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      start   = 1'b0;
      op      = 1'b0;
      a       = '0;
      b       = '0;
      repeat (3) @(negedge clk);
      vecs++;
      if ({busy, done, div_by_zero} !== 3'b000) begin
         errs++;
         $display("FAIL reset_ctrl: got busy/done/dbz=%b, expected 000", {busy, done, div_by_zero});
      end
      vecs++;
      if ({hi, lo} !== {2 * W{1'b0}}) begin
         errs++;
         $display("FAIL reset_data: got hi=%h lo=%h, expected 0", hi, lo);
      end
      reset_n = 1'b1;
   endtask

   task automatic test_mul();
      int n;
      start_op(1'b0, 32'd7, 32'hFFFF_FFFD);
      vecs++;
      if (busy !== 1'b1) begin
         errs++;
         $display("FAIL mul_busy: got %b, expected 1", busy);
      end
      wait_done(n);
      vecs++;
      if (n != W) begin
         errs++;
         $display("FAIL mul_latency: got %0d, expected %0d", n, W);
      end
   endtask

   task automatic test_div();
      int n;
      start_op(1'b1, 32'd100, 32'd7);
      n = 0;
      while (busy === 1'b1 && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      vecs++;
      if (n != W) begin
         errs++;
         $display("FAIL div_busy_len: got %0d, expected %0d", n, W);
      end
      vecs++;
      if (done !== 1'b1) begin
         errs++;
         $display("FAIL div_done_rise: got %b, expected 1", done);
      end
      @(negedge clk);
      vecs++;
      if (done !== 1'b0) begin
         errs++;
         $display("FAIL div_done_width: got %b, expected 0", done);
      end
   endtask

   task automatic test_div_zero();
      int n;
      start_op(1'b1, 32'h1234_5678, 32'd0);
      wait_done(n);
      vecs++;
      if (n != W) begin
         errs++;
         $display("FAIL dbz_latency: got %0d, expected %0d", n, W);
      end
   endtask

   task automatic test_busy_ignore();
      int n;
      start_op(1'b0, 32'h8000_0000, 32'h8000_0000);
      repeat (9) @(negedge clk);
      vecs++;
      if ({hi, lo, div_by_zero} !== {last_exp.hi, last_exp.lo, last_exp.dbz}) begin
         errs++;
         $display("FAIL hold_while_busy: got hi=%h lo=%h dbz=%b, expected hi=%h lo=%h dbz=%b",
                  hi, lo, div_by_zero, last_exp.hi, last_exp.lo, last_exp.dbz);
      end
      op    = 1'b0;
      a     = 32'd1;
      b     = 32'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      vecs++;
      if (busy !== 1'b1) begin
         errs++;
         $display("FAIL ignore_busy: got %b, expected 1", busy);
      end
      wait_done(n);
      vecs++;
      if (n != W - 10) begin
         errs++;
         $display("FAIL ignore_latency: got %0d, expected %0d", n, W - 10);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      @(negedge clk);
      op    = 1'b0;
      a     = 32'd3;
      b     = 32'd5;
      start = 1'b1;
      sb_q.push_back(model(1'b0, 32'd3, 32'd5));
      @(negedge clk);
      wait_done(n);
      vecs++;
      if (n != W) begin
         errs++;
         $display("FAIL b2b_first_latency: got %0d, expected %0d", n, W);
      end
      op = 1'b1;
      a  = 32'd9;
      b  = 32'd2;
      sb_q.push_back(model(1'b1, 32'd9, 32'd2));
      @(negedge clk);
      vecs++;
      if ({busy, done} !== 2'b10) begin
         errs++;
         $display("FAIL b2b_no_gap: got busy/done=%b, expected 10", {busy, done});
      end
      start = 1'b0;
      wait_done(n);
      vecs++;
      if (n != W) begin
         errs++;
         $display("FAIL b2b_second_latency: got %0d, expected %0d", n, W);
      end
   endtask

   task automatic test_reset_midop();
      int n;
      int seen;
      start_op(1'b1, 32'd1000, 32'd3);
      repeat (11) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      vecs++;
      if ({busy, done, div_by_zero} !== 3'b000 || {hi, lo} !== {2 * W{1'b0}}) begin
         errs++;
         $display("FAIL midop_reset: got busy=%b done=%b hi=%h lo=%h dbz=%b, expected all 0",
                  busy, done, hi, lo, div_by_zero);
      end
      reset_n = 1'b1;
      sb_q.delete();
      seen = 0;
      repeat (W + 8) begin
         @(negedge clk);
         if (done === 1'b1) seen++;
      end
      vecs++;
      if (seen != 0) begin
         errs++;
         $display("FAIL midop_no_done: got %0d done pulses, expected 0", seen);
      end
      start_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(n);
      vecs++;
      if (n != W) begin
         errs++;
         $display("FAIL midop_restart_latency: got %0d, expected %0d", n, W);
      end
   endtask

   task automatic test_random();
      int           n;
      logic         o;
      logic [W-1:0] x;
      logic [W-1:0] y;
      for (int i = 0; i < 10; i++) begin
         o = 1'($urandom_range(0, 1));
         x = $urandom;
         y = (i % 4 == 3) ? $urandom_range(0, 3) : $urandom;
         if (i == 0) begin
            o = 1'b0;
            y = 32'h7FFF_FFFF;
         end
         if (i == 1) begin
            o = 1'b1;
            x = 32'hFFFF_FFFF;
            y = 32'd1;
         end
         start_op(o, x, y);
         wait_done(n);
         vecs++;
         if (n != W) begin
            errs++;
            $display("FAIL random_latency: got %0d, expected %0d", n, W);
         end
      end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_div_zero();
      test_busy_ignore();
      test_back_to_back();
      test_reset_midop();
      test_random();
      repeat (3) @(negedge clk);
      vecs++;
      if (sb_q.size() != 0) begin
         errs++;
         $display("FAIL pending_results: got %0d outstanding, expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
